// File: rtl/module_controlador_hamming_pkg.sv
// Shared types and constants for the SECDED Hamming(8,4) controller.
// Code word layout: {p0,d4,d3,d2,p3,d1,p2,p1}; bit i holds Hamming position i+1.
package module_controlador_hamming_pkg;

  localparam int CW_WIDTH   = 8;
  localparam int DATA_WIDTH = 4;
  localparam int SYN_WIDTH  = 3;
  localparam int CNT_WIDTH  = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVALUA  = 2'd1,
    CORRIGE = 2'd2,
    ENTREGA = 2'd3
  } estado_fsm_t;

  typedef enum logic [1:0] {
    NINGUNO = 2'b00,
    SIMPLE  = 2'b01,
    DOBLE   = 2'b10,
    PARIDAD = 2'b11
  } estado_error_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extrae_datos(input logic [CW_WIDTH-1:0] w);
    return {w[6], w[5], w[4], w[2]};
  endfunction

endpackage

// File: rtl/module_controlador_hamming_detector.sv
// Combinational SECDED detector: syndrome over the 7 Hamming bits plus
// overall parity across all 8 bits (odd parity => an odd number of flips).
module module_detector_error
  import module_controlador_hamming_pkg::*;
(
  input  logic [CW_WIDTH-1:0]  palabra,
  output logic [SYN_WIDTH-1:0] sindrome,
  output logic                 paridad,
  output logic                 doble
);

  // Syndrome bit k covers every position whose 1-based index has bit k set.
  always_comb begin
    sindrome = '0;
    for (int k = 0; k < SYN_WIDTH; k++) begin
      for (int i = 0; i < CW_WIDTH - 1; i++) begin
        if ((((i + 1) >> k) & 1) == 1) sindrome[k] = sindrome[k] ^ palabra[i];
      end
    end
  end

  assign paridad = ^palabra;
  assign doble   = (sindrome != '0) && !paridad;

endmodule

// File: rtl/module_controlador_hamming.sv
// Four-state Hamming controller: latch word, evaluate syndrome, correct/classify,
// deliver with valid/ready handshake. Keeps saturating error counters.
module module_controlador_hamming
  import module_controlador_hamming_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW_WIDTH-1:0]   datos_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dato_corregido,
  output logic [SYN_WIDTH-1:0]  sindrome_out,
  output logic [1:0]            estado_error,
  output logic [CNT_WIDTH-1:0]  cnt_simples,
  output logic [CNT_WIDTH-1:0]  cnt_dobles,
  input  logic                  clr_cnt
);

  estado_fsm_t            state_q, state_d;
  logic [CW_WIDTH-1:0]    palabra_q, palabra_d;
  logic [SYN_WIDTH-1:0]   sind_ev_q, sind_ev_d;
  logic                   par_ev_q, par_ev_d;
  logic                   doble_ev_q, doble_ev_d;
  logic [DATA_WIDTH-1:0]  dato_q, dato_d;
  logic [SYN_WIDTH-1:0]   sind_q, sind_d;
  estado_error_t          err_q, err_d;
  logic [CNT_WIDTH-1:0]   cnt_s_q, cnt_s_d;
  logic [CNT_WIDTH-1:0]   cnt_d_q, cnt_d_d;

  logic [SYN_WIDTH-1:0]   det_sind;
  logic                   det_par;
  logic                   det_doble;
  logic [CW_WIDTH-1:0]    corregida;
  estado_error_t          clase;

  module_detector_error u_detector (
    .palabra  (palabra_q),
    .sindrome (det_sind),
    .paridad  (det_par),
    .doble    (det_doble)
  );

  // Classification uses the evaluation registers, never the live detector.
  always_comb begin
    corregida = palabra_q;
    clase     = NINGUNO;
    if (doble_ev_q) begin
      clase = DOBLE;
    end else if (sind_ev_q != '0) begin
      clase = SIMPLE;
      for (int i = 0; i < CW_WIDTH - 1; i++) begin
        if (sind_ev_q == 3'(i + 1)) corregida[i] = ~palabra_q[i];
      end
    end else if (par_ev_q) begin
      clase = PARIDAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    palabra_d  = palabra_q;
    sind_ev_d  = sind_ev_q;
    par_ev_d   = par_ev_q;
    doble_ev_d = doble_ev_q;
    dato_d     = dato_q;
    sind_d     = sind_q;
    err_d      = err_q;
    cnt_s_d    = cnt_s_q;
    cnt_d_d    = cnt_d_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          palabra_d = datos_in;
          state_d   = EVALUA;
        end
      end
      EVALUA: begin
        sind_ev_d  = det_sind;
        par_ev_d   = det_par;
        doble_ev_d = det_doble;
        state_d    = CORRIGE;
      end
      CORRIGE: begin
        dato_d = extrae_datos(corregida);
        sind_d = sind_ev_q;
        err_d  = clase;
        if (clase == SIMPLE || clase == PARIDAD) cnt_s_d = sat_inc(cnt_s_q);
        if (clase == DOBLE)                      cnt_d_d = sat_inc(cnt_d_q);
        state_d = ENTREGA;
      end
      ENTREGA: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over an increment landing in the same cycle.
    if (clr_cnt) begin
      cnt_s_d = '0;
      cnt_d_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      palabra_q  <= '0;
      sind_ev_q  <= '0;
      par_ev_q   <= 1'b0;
      doble_ev_q <= 1'b0;
      dato_q     <= '0;
      sind_q     <= '0;
      err_q      <= NINGUNO;
      cnt_s_q    <= '0;
      cnt_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      palabra_q  <= palabra_d;
      sind_ev_q  <= sind_ev_d;
      par_ev_q   <= par_ev_d;
      doble_ev_q <= doble_ev_d;
      dato_q     <= dato_d;
      sind_q     <= sind_d;
      err_q      <= err_d;
      cnt_s_q    <= cnt_s_d;
      cnt_d_q    <= cnt_d_d;
    end
  end

  assign dato_corregido = dato_q;
  assign sindrome_out   = sind_q;
  assign estado_error   = err_q;
  assign cnt_simples    = cnt_s_q;
  assign cnt_dobles     = cnt_d_q;

endmodule

// File: tb/tb_module_controlador_hamming.sv
// Directed + random bench for the Hamming controller against a positional
// SECDED model (syndrome = XOR of 1-based positions of set bits).
module tb_module_controlador_hamming;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, clr_cnt;
  logic [7:0] datos_in;
  logic       in_ready, out_valid;
  logic [3:0] dato_corregido;
  logic [2:0] sindrome_out;
  logic [1:0] estado_error;
  logic [7:0] cnt_simples, cnt_dobles;

  int errors = 0;
  int checks = 0;
  int ms = 0;
  int md = 0;

  module_controlador_hamming dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .datos_in       (datos_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dato_corregido (dato_corregido),
    .sindrome_out   (sindrome_out),
    .estado_error   (estado_error),
    .cnt_simples    (cnt_simples),
    .cnt_dobles     (cnt_dobles),
    .clr_cnt        (clr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] w, output logic [3:0] d,
                                output logic [2:0] s, output logic [1:0] e);
    int         syn;
    bit         odd;
    logic [7:0] c;
    syn = 0;
    for (int i = 0; i < 7; i++) if (w[i]) syn = syn ^ (i + 1);
    odd = ($countones(w) % 2) == 1;
    c = w;
    if (syn != 0 && odd) c[syn - 1] = ~c[syn - 1];
    if (syn == 0) e = odd ? 2'b11 : 2'b00;
    else          e = odd ? 2'b01 : 2'b10;
    s = 3'(syn);
    d = {c[6], c[5], c[4], c[2]};
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_word(input logic [7:0] w, input int hold, input bit clr_inc,
                          input string tag);
    logic [3:0] ed;
    logic [2:0] es;
    logic [1:0] ee;
    model(w, ed, es, ee);
    out_ready = 1'b0;
    chk({tag, ":in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    datos_in = w;
    @(negedge clk);
    datos_in = ~w;
    chk({tag, ":lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ":lat2"}, out_valid, 0);
    clr_cnt = clr_inc;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk({tag, ":lat3"}, out_valid, 1);
    if (clr_inc) begin
      ms = 0;
      md = 0;
    end else if (ee == 2'b01 || ee == 2'b11) begin
      ms = (ms < 255) ? ms + 1 : 255;
    end else if (ee == 2'b10) begin
      md = (md < 255) ? md + 1 : 255;
    end
    chk({tag, ":dato"}, dato_corregido, ed);
    chk({tag, ":sind"}, sindrome_out, es);
    chk({tag, ":err"}, estado_error, ee);
    chk({tag, ":cnt_s"}, cnt_simples, ms);
    chk({tag, ":cnt_d"}, cnt_dobles, md);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, out_valid, 1);
      chk({tag, ":hold_dato"}, dato_corregido, ed);
      chk({tag, ":hold_sind"}, sindrome_out, es);
      chk({tag, ":hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":done_valid"}, out_valid, 0);
    chk({tag, ":keep_dato"}, dato_corregido, ed);
    chk({tag, ":keep_err"}, estado_error, ee);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; datos_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst:in_ready", in_ready, 1);
    chk("rst:out_valid", out_valid, 0);
    chk("rst:dato", dato_corregido, 0);
    chk("rst:sind", sindrome_out, 0);
    chk("rst:err", estado_error, 0);
    chk("rst:cnt_s", cnt_simples, 0);
    chk("rst:cnt_d", cnt_dobles, 0);

    run_word(8'h55, 0, 1'b0, "clean");
    chk("clean:dato_const", dato_corregido, 4'b1011);
    run_word(8'h45, 0, 1'b0, "single");
    chk("single:sind_const", sindrome_out, 3'd5);
    run_word(8'h56, 0, 1'b0, "double");
    chk("double:err_const", estado_error, 2'b10);
    run_word(8'hD5, 0, 1'b0, "p0");
    chk("p0:err_const", estado_error, 2'b11);

    run_word(8'h45, 5, 1'b0, "backpressure");

    // Reset while the word is in EVALUA: the word must vanish.
    in_valid = 1'b1;
    datos_in = 8'h56;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ms = 0;
    md = 0;
    chk("rst_ev:in_ready", in_ready, 1);
    chk("rst_ev:out_valid", out_valid, 0);
    chk("rst_ev:dato", dato_corregido, 0);
    chk("rst_ev:sind", sindrome_out, 0);
    chk("rst_ev:err", estado_error, 0);
    chk("rst_ev:cnt_s", cnt_simples, 0);
    chk("rst_ev:cnt_d", cnt_dobles, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ev:no_output", out_valid, 0);
    end

    for (int n = 0; n < 40; n++) begin
      w = 8'($urandom_range(0, 255));
      run_word(w, $urandom_range(0, 2), 1'b0, "rand");
    end

    for (int n = 0; n < 260; n++) begin
      do w = 8'($urandom_range(0, 255)); while (($countones(w) % 2) == 0);
      run_word(w, 0, 1'b0, "sat");
    end
    chk("sat:cnt_s_ff", cnt_simples, 8'hFF);

    run_word(8'h45, 0, 1'b1, "clr_vs_inc");
    chk("clr:cnt_s_zero", cnt_simples, 0);
    run_word(8'h56, 1, 1'b0, "after_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/module_controlador_hamming.md
MODULE_CONTROLADOR_HAMMING -- requirements
Module: module_controlador_hamming

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  code word on datos_in is valid.
REQ-004 SHALL have port: in_ready  output  1  block can accept a word.
REQ-005 SHALL have port: datos_in  input  8  code word, bit order [7:0] = {p0,d4,d3,d2,p3,d1,p2,p1}, so bit0=p1, bit7=p0.
REQ-006 SHALL have port: out_valid  output  1  result is valid.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have port: dato_corregido  output  4  data {d4,d3,d2,d1}.
REQ-009 SHALL have port: sindrome_out  output  3  registered syndrome {s2,s1,s0}.
REQ-010 SHALL have port: estado_error  output  2  00 none, 01 single corrected, 10 double detected, 11 only p0 wrong.
REQ-011 SHALL have port: cnt_simples  output  8  saturating count of single-error words (codes 01 and 11).
REQ-012 SHALL have port: cnt_dobles  output  8  saturating count of double-error words.
REQ-013 SHALL have port: clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-014 SHALL implement an FSM with states IDLE, EVALUA, CORRIGE, ENTREGA.
REQ-015 SHALL assert in_ready only in IDLE; in_valid&&in_ready latches datos_in into an internal word register and moves to EVALUA.
REQ-016 SHALL, in EVALUA, register the detector syndrome, global parity and double flag, then go to CORRIGE.
REQ-017 SHALL, in CORRIGE, classify the word. Syndrome s!=0 with odd parity: flip word bit (s-1), code 01. s!=0 with even parity: no flip, code 10. s==0 with odd parity: code 11, data untouched. s==0 with even parity: code 00. Then go to ENTREGA.
REQ-018 SHALL assert out_valid only in ENTREGA, holding dato_corregido, sindrome_out and estado_error stable until out_valid&&out_ready, then return to IDLE.
REQ-019 SHALL give a latency of exactly 3 cycles from the accepting edge to out_valid high; throughput is one word per 4 cycles when out_ready is held high.
REQ-020 SHALL take dato_corregido as {w[6],w[5],w[4],w[2]} of the post-correction word; for code 10 it is the uncorrected word.
REQ-021 SHALL update counters once per word on the CORRIGE->ENTREGA transition, saturating at 8'hFF with no wrap.
REQ-022 SHALL give clr_cnt priority over a same-cycle increment; result is 0.
REQ-023 SHALL ignore in_valid outside IDLE; the latched word cannot be overwritten mid-operation.
REQ-024 SHALL keep dato_corregido, sindrome_out and estado_error at last-delivered values outside ENTREGA.

Reset
REQ-025 SHALL, when rst is high at a clock edge, go to IDLE from any state, drop any in-flight word, and clear in_ready?=1 after reset, out_valid=0, dato_corregido=0, sindrome_out=0, estado_error=00, cnt_simples=0, cnt_dobles=0, word register=0.
REQ-026 SHALL give rst priority over clr_cnt and all handshakes.

Structure
REQ-027 SHALL define a shared package holding an FSM state enum and an estado_error enum (NINGUNO, SIMPLE, DOBLE, PARIDAD), plus constants CW_WIDTH=8, DATA_WIDTH=4 and CNT_MAX=8'hFF.
REQ-028 SHALL instantiate module_detector_error once as the only sub-module, fed from the internal word register.

Verification
REQ-029 SHALL test a clean word: datos_in=8'h55 -> after 3 cycles out_valid=1, dato_corregido=4'b1011, sindrome_out=0, estado_error=00, counters unchanged.
REQ-030 SHALL test a single error: datos_in=8'h45 (bit4 flipped) -> sindrome_out=3'd5, dato_corregido=4'b1011, estado_error=01, cnt_simples+1.
REQ-031 SHALL test a double error: datos_in=8'h56 -> sindrome_out=3'd3, estado_error=10, dato_corregido=4'b1011 uncorrected, cnt_dobles+1.
REQ-032 SHALL test a p0-only error: datos_in=8'hD5 -> sindrome_out=0, estado_error=11, dato_corregido=4'b1011, cnt_simples+1.
REQ-033 SHALL test backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; assert rst in EVALUA -> next cycle IDLE, all outputs at reset values.
REQ-034 SHALL test saturation and clear: 260 single-error words -> cnt_simples=8'hFF; clr_cnt coincident with an increment -> 0.
